// File: rtl/bounce_gen.sv
// Contact-bounce emulator: a clean level change on level_in becomes a burst of
// LFSR-timed glitch edges on signal_out before it settles at the new level.
module bounce_gen #(
    parameter int unsigned CLK_FREQ_HZ    = 12000000,
    parameter int unsigned BOUNCE_TIME_MS = 5,
    parameter int unsigned N_TOGGLES      = 6,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    input  logic level_in,
    input  logic bounce_en,
    output logic signal_out,
    output logic busy
);

    localparam int unsigned W        = CLK_FREQ_HZ * BOUNCE_TIME_MS / 1000;
    localparam int unsigned SEG_BITS = $clog2(W / N_TOGGLES);
    localparam int unsigned CNT_W    = (SEG_BITS < 1) ? 1 : SEG_BITS;
    localparam int unsigned TGL_W    = $clog2(N_TOGGLES + 1);
    localparam logic [15:0] SEG_MASK = 16'((32'd1 << (CNT_W - 1)) - 32'd1);
    localparam logic [15:0] LFSR_TAP = 16'hB400;

    typedef enum logic {StStable, StBounce} state_e;

    state_e             r_state, w_state_nxt;
    logic [15:0]        r_lfsr, w_lfsr_nxt;
    logic               r_lvl;
    logic               r_cur_level, w_cur_level_nxt;
    logic               r_target, w_target_nxt;
    logic               r_out, w_out_nxt;
    logic               r_busy, w_busy_nxt;
    logic [CNT_W-1:0]   r_hold, w_hold_nxt;
    logic [TGL_W-1:0]   r_toggles, w_toggles_nxt;
    logic [CNT_W-1:0]   w_hold_len;

    // Galois step; free-running so burst timing depends on cycles since reset.
    assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAP : 16'h0000);
    assign w_hold_len = CNT_W'(r_lfsr & SEG_MASK) + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StStable;
            r_lfsr      <= LFSR_SEED;
            r_lvl       <= 1'b0;
            r_cur_level <= 1'b0;
            r_target    <= 1'b0;
            r_out       <= 1'b0;
            r_busy      <= 1'b0;
            r_hold      <= '0;
            r_toggles   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lfsr      <= w_lfsr_nxt;
            r_lvl       <= level_in;
            r_cur_level <= w_cur_level_nxt;
            r_target    <= w_target_nxt;
            r_out       <= w_out_nxt;
            r_busy      <= w_busy_nxt;
            r_hold      <= w_hold_nxt;
            r_toggles   <= w_toggles_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cur_level_nxt = r_cur_level;
        w_target_nxt    = r_target;
        w_out_nxt       = r_out;
        w_busy_nxt      = r_busy;
        w_hold_nxt      = r_hold;
        w_toggles_nxt   = r_toggles;

        unique case (r_state)
            StStable: begin
                w_busy_nxt = 1'b0;
                if (r_lvl != r_cur_level) begin
                    w_out_nxt = r_lvl;
                    if (!bounce_en) begin
                        w_cur_level_nxt = r_lvl;
                    end else begin
                        w_target_nxt  = r_lvl;
                        w_toggles_nxt = TGL_W'(N_TOGGLES);
                        w_hold_nxt    = w_hold_len;
                        w_busy_nxt    = 1'b1;
                        w_state_nxt   = StBounce;
                    end
                end
            end
            StBounce: begin
                if (r_hold == CNT_W'(1)) begin
                    if (r_toggles > TGL_W'(1)) begin
                        w_out_nxt     = ~r_out;
                        w_toggles_nxt = r_toggles - TGL_W'(1);
                        w_hold_nxt    = w_hold_len;
                    end else begin
                        // Final toggle lands on the target by construction (even count).
                        w_out_nxt       = r_target;
                        w_cur_level_nxt = r_target;
                        w_toggles_nxt   = '0;
                        w_hold_nxt      = '0;
                        w_busy_nxt      = 1'b0;
                        w_state_nxt     = StStable;
                    end
                end else begin
                    w_hold_nxt = r_hold - CNT_W'(1);
                end
            end
            default: w_state_nxt = StStable;
        endcase
    end

    assign signal_out = r_out;
    assign busy       = r_busy;

endmodule

// File: tb/tb_bounce_gen.sv
// Scoreboard bench for bounce_gen: expected edge schedule is derived from an
// independent LFSR model and compared against edges seen on signal_out.
module tb_bounce_gen;

    localparam int          N_TGL  = 6;
    localparam logic [15:0] SEED   = 16'hACE1;
    localparam int          MASK   = 7;
    localparam int          DB_LEN = 110;

    typedef struct {
        int   t;
        logic v;
        logic b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic level_in = 1'b0;
    logic bounce_en = 1'b1;
    logic signal_out;
    logic busy;

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc;
    exp_t sb[$];
    int   edge_t[$];
    int   gaps_a[$];
    logic prev_out = 1'b0;

    logic db_out, db_last;
    int   db_cnt, db_edges;

    bounce_gen #(
        .CLK_FREQ_HZ   (1000),
        .BOUNCE_TIME_MS(100),
        .N_TOGGLES     (N_TGL),
        .LFSR_SEED     (SEED)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .level_in  (level_in),
        .bounce_en (bounce_en),
        .signal_out(signal_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [15:0] lfsr_adv(input int n);
        logic [15:0] l;
        l = SEED;
        for (int i = 0; i < n; i++) l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
        return l;
    endfunction

    task automatic push_burst(input int start, input logic tgt, output int last);
        int   t;
        logic v;
        t = start;
        v = tgt;
        sb.push_back('{t, v, 1'b1});
        for (int i = 1; i <= N_TGL; i++) begin
            t = t + 1 + int'(lfsr_adv(t - 1) & 16'(MASK));
            v = ~v;
            sb.push_back('{t, v, (i == N_TGL) ? 1'b0 : 1'b1});
        end
        last = t;
    endtask

    task automatic drive(input logic lv, output int c);
        @(negedge clk);
        level_in = lv;
        c = cyc;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("timeout_pending_edges", sb.size(), 0);
            sb.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    // Edge monitor: every change on signal_out must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_out = 1'b0;
        end else if (signal_out !== prev_out) begin
            prev_out = signal_out;
            edge_t.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_edge", cyc, -1);
            end else begin
                e = sb.pop_front();
                chk("edge_cycle", cyc, e.t);
                chk("edge_value", int'(signal_out), int'(e.v));
                chk("edge_busy", int'(busy), int'(e.b));
            end
        end
    end

    // Simple integrating debouncer used for the loopback check.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            db_out   <= 1'b0;
            db_last  <= 1'b0;
            db_cnt   <= 0;
            db_edges <= 0;
        end else begin
            db_last <= signal_out;
            if (signal_out != db_last) db_cnt <= 0;
            else if (db_cnt < DB_LEN) db_cnt <= db_cnt + 1;
            else if (db_out != signal_out) begin
                db_out   <= signal_out;
                db_edges <= db_edges + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 20000", cyc);
        $fatal(1);
    end

    initial begin
        int c, c2, last, last2, g, n;

        // Reset with level_in high: outputs held low.
        rst = 1'b1;
        level_in = 1'b1;
        bounce_en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_signal_out", int'(signal_out), 0);
        chk("rst_busy", int'(busy), 0);

        // Bounce profile run A: release with lvl pending, first edge at cycle 2.
        @(negedge clk);
        edge_t.delete();
        rst = 1'b0;
        push_burst(2, 1'b1, last);
        wait_idle(200);
        chk("profile_edges", edge_t.size(), N_TGL + 1);
        if (edge_t.size() == N_TGL + 1) begin
            for (int i = 1; i <= N_TGL; i++) begin
                g = edge_t[i] - edge_t[i-1];
                gaps_a.push_back(g);
                chk("profile_gap_range", int'(g >= 1 && g <= MASK + 1), 1);
            end
            chk("profile_burst_len", int'(edge_t[N_TGL] - edge_t[0] <= N_TGL * (MASK + 1)), 1);
        end
        chk("profile_final", int'(signal_out), 1);
        chk("profile_busy_idle", int'(busy), 0);

        // Pass-through: 1->0, 0->1, each a single edge two cycles out, busy low.
        bounce_en = 1'b0;
        drive(1'b0, c);
        sb.push_back('{c + 2, 1'b0, 1'b0});
        wait_idle(20);
        edge_t.delete();
        drive(1'b1, c);
        sb.push_back('{c + 2, 1'b1, 1'b0});
        wait_idle(20);
        chk("pt_edge_count", edge_t.size(), 1);
        chk("pt_busy", int'(busy), 0);
        drive(1'b0, c);
        sb.push_back('{c + 2, 1'b0, 1'b0});
        wait_idle(20);

        // Input change mid-burst: second burst starts one edge after the first ends.
        bounce_en = 1'b1;
        edge_t.delete();
        drive(1'b1, c);
        push_burst(c + 2, 1'b1, last);
        repeat (2) @(negedge clk);
        drive(1'b0, c2);
        push_burst(last + 1, 1'b0, last2);
        wait_idle(300);
        chk("mid_edge_count", edge_t.size(), 2 * (N_TGL + 1));
        chk("mid_final", int'(signal_out), 0);

        // Reset during the third hold of a burst.
        drive(1'b1, c);
        push_burst(c + 2, 1'b1, last);
        n = 0;
        edge_t.delete();
        while (edge_t.size() < 3 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("mid_rst_reached_hold3", edge_t.size(), 3);
        rst = 1'b1;
        #1;
        chk("mid_rst_signal_out", int'(signal_out), 0);
        chk("mid_rst_busy", int'(busy), 0);
        sb.delete();
        repeat (2) @(negedge clk);

        // Run B must reproduce the gap sequence of run A.
        edge_t.delete();
        rst = 1'b0;
        push_burst(2, 1'b1, last);
        wait_idle(200);
        chk("rerun_edges", edge_t.size(), N_TGL + 1);
        if (edge_t.size() == N_TGL + 1 && gaps_a.size() == N_TGL) begin
            for (int i = 1; i <= N_TGL; i++) chk("rerun_gap", edge_t[i] - edge_t[i-1], gaps_a[i-1]);
        end

        // Loopback: debouncer sees one clean transition per level change.
        repeat (DB_LEN + 20) @(negedge clk);
        chk("db_edges_after_rise", db_edges, 1);
        chk("db_level_high", int'(db_out), 1);
        drive(1'b0, c);
        push_burst(c + 2, 1'b0, last);
        wait_idle(200);
        repeat (DB_LEN + 20) @(negedge clk);
        chk("db_edges_after_fall", db_edges, 2);
        chk("db_level_low", int'(db_out), 0);
        chk("end_busy", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bounce_gen.md
# bounce_gen

Synthesizable contact-bounce emulator: turns a clean level on `level_in` into a burst of pseudo-random glitch edges on `signal_out` before settling to the new level. It is the stimulus-side counterpart of the button debouncer. It drives the debouncer input in hardware self-test and in simulation benches on the Poncho board designs. All randomness comes from an internal 16-bit LFSR, so sequences are deterministic per seed.

## Interface
- `CLK_FREQ_HZ`, 12000000, clock frequency in Hz.
- `BOUNCE_TIME_MS`, 5, upper bound of bounce window; W = CLK_FREQ_HZ*BOUNCE_TIME_MS/1000 cycles.
- `N_TOGGLES`, 6, glitch toggles after the first edge; must be even and ≥2.
- `LFSR_SEED`, 16'hACE1, LFSR reset value; must be nonzero.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `level_in` in 1: clean requested level, synchronous to clk.
- `bounce_en` in 1: 1 = emulate bounce, 0 = pass-through; sampled only when a transition starts.
- `signal_out` out 1: emulated noisy contact output, registered.
- `busy` out 1: high while a bounce burst is in progress.

## Operation
- Derived constants:
  - SEG_BITS = $clog2(W/N_TOGGLES).
  - SEG_MASK = 2^(SEG_BITS-1) - 1.
  - hold_len = 1 + (lfsr & SEG_MASK), range 1..SEG_MASK+1.
  - Total burst ≤ N_TOGGLES*(SEG_MASK+1) ≤ W.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). Advances every clock, including idle. Never stalls.
- `level_in` is registered once into lvl_q. cur_level holds the settled output level.
- State STABLE:
  - `signal_out` = cur_level, `busy` = 0.
  - If lvl_q != cur_level and bounce_en=0: set signal_out = cur_level = lvl_q. Stay in STABLE.
  - If lvl_q != cur_level and bounce_en=1:
    - target ← lvl_q; signal_out ← lvl_q (first edge).
    - toggles_left ← N_TOGGLES; hold counter ← hold_len.
    - busy ← 1; go to BOUNCE.
- State BOUNCE:
  - Hold counter decrements each clock.
  - On the clock it would reach 0: signal_out toggles and toggles_left decrements.
  - If toggles_left was >1, reload the counter with a fresh hold_len (current LFSR value).
  - If toggles_left was 1, the toggle is the last one: signal_out = target, cur_level ← target, busy ← 0, go to STABLE.
- `signal_out` stays constant for exactly hold_len cycles between consecutive edges of a burst.
- Changes on `level_in` during BOUNCE are ignored. On return to STABLE, lvl_q is compared again; a pending difference starts a new burst or pass-through on the next edge.
- Reset values: signal_out=0, busy=0, cur_level=0, state STABLE, lfsr=LFSR_SEED, counters 0.
- Reset mid-burst aborts immediately to the reset values. The LFSR sequence restarts from the seed.

## Timing
- `level_in` change set up before clock edge k: lvl_q updates at k, and signal_out changes at edge k+1 (2-cycle latency). Same for pass-through and for the first bounce edge.
- `busy` rises on the same edge as the first bounce edge.
- `busy` falls on the same edge as the final toggle.
- Earliest next transition start: one edge after busy falls.
- Burst produces exactly N_TOGGLES+1 edges on signal_out; final level = target.
- A level_in pulse shorter than 1 cycle is not detected (no synchronizer; the source must be clk-synchronous).
- bounce_en changes have no effect mid-burst.

## Test plan
- Reset: assert rst with level_in=1 → signal_out=0, busy=0 during rst. After release, edges start 2 cycles after the first clock with lvl_q=1.
- Pass-through: bounce_en=0, level_in 0→1 before edge k → signal_out=1 at edge k+1, exactly one edge, busy stays 0.
- Bounce profile: CLK_FREQ_HZ=1000, BOUNCE_TIME_MS=100, N_TOGGLES=6 (W=100, SEG_MASK=7); level_in 0→1 →
  - exactly 7 edges, each gap 1..8 cycles, final signal_out=1;
  - busy high first edge..last edge; burst ≤48 cycles;
  - gaps match a bit-exact LFSR model seeded 16'hACE1.
- Input change mid-burst: level_in 0→1, then 1→0 three cycles later → first burst ends at 1, busy drops, second burst starts next edge and ends at 0. No edges are lost or merged.
- Reset mid-burst: assert rst during the 3rd hold → signal_out=0, busy=0 immediately. After release, a repeated 0→1 reproduces the gap sequence of the bounce-profile run.
- Loopback: chain into the debouncer with debounce time > BOUNCE_TIME_MS → debouncer output shows a single clean transition per level_in change.
